// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard for decode: RAW/WAW stall detection,
// flush suppression and a saturating stall-cycle counter.
//
// Ports:
//   clk, clrn                 clock, async active-high reset
//   id_valid, id_flush        ID slot occupancy and squash
//   id_rs/id_rt, id_use_*     source registers and whether they are read
//   id_wreg, id_rn, id_lat    destination write, register, extra latency
//   stall, stall_why, issue   hazard outputs to IF/ID and EXE
//   busy_vec, stall_cnt       per-register busy flags, stall counter
module hazard_scoreboard #(
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG),
    parameter int MAXLAT = 4,
    parameter int LW     = $clog2(MAXLAT + 1),
    parameter int CW     = 32
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic            id_wreg,
    input  logic [AW-1:0]   id_rn,
    input  logic [LW-1:0]   id_lat,
    input  logic            id_flush,
    output logic            stall,
    output logic [1:0]      stall_why,
    output logic            issue,
    output logic [NREG-1:0] busy_vec,
    output logic [CW-1:0]   stall_cnt
);

    localparam logic [LW-1:0] LMAX = LW'(MAXLAT);

    logic [LW-1:0] r_cnt [NREG];
    logic [CW-1:0] r_stall_cnt;

    logic [LW-1:0] w_lat;
    logic          w_raw_rs;
    logic          w_raw_rt;
    logic          w_waw;
    logic          w_live;

    assign w_lat = (id_lat > LMAX) ? LMAX : id_lat;

    assign w_raw_rs = id_use_rs && (id_rs != '0) && (r_cnt[id_rs] != '0);
    assign w_raw_rt = id_use_rt && (id_rt != '0) && (r_cnt[id_rt] != '0);
    // An older write still pending longer than the new one would
    // land after it and clobber the younger result.
    assign w_waw    = id_wreg && (id_rn != '0) && (r_cnt[id_rn] > w_lat);

    assign w_live = id_valid && !id_flush;
    assign stall  = w_live && (w_raw_rs || w_raw_rt || w_waw);
    assign issue  = w_live && !stall;

    always_comb begin
        stall_why = 2'b00;
        if (stall) begin
            if (w_raw_rs)      stall_why = 2'b01;
            else if (w_raw_rt) stall_why = 2'b10;
            else               stall_why = 2'b11;
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 1; r < NREG; r++) begin
            busy_vec[r] = (r_cnt[r] != '0);
        end
    end

    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            r_cnt[0] <= '0;
            for (int r = 1; r < NREG; r++) begin
                // A new write replaces the countdown outright.
                if (issue && id_wreg && (id_rn == AW'(r))) begin
                    r_cnt[r] <= w_lat;
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule
